// File: rtl/systolic_pkg.sv
// Shared constants, FSM state encoding and lane helper for the systolic
// matrix-multiply sequencer and the array it drives.
package systolic_pkg;

  localparam int N       = 16;
  localparam int DW      = 8;
  localparam int RW      = 23;
  localparam int TIMEOUT = 1024;
  localparam int IW      = 4;                 // row/column index width
  localparam int STEPS   = 2 * N - 1;         // wavefront steps per run
  localparam int SW      = 5;                 // step counter width
  localparam int DIFW    = SW + 1;            // step minus lane, with wrap guard bit
  localparam int TW      = $clog2(TIMEOUT);   // WAIT cycle counter width

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    WAIT  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  // Extract lane k of a packed N-lane operand bus
  function automatic logic [DW-1:0] lane_sel(input logic [N*DW-1:0] bus_v, input logic [IW-1:0] k);
    return bus_v[DW*k +: DW];
  endfunction

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// Host-side bus of the sequencer: operand load beats in, result stream out.
interface systolic_seq_ctrl_if;
  import systolic_pkg::*;

  logic              ld_valid;
  logic              ld_ready;
  logic              ld_sel;
  logic [IW-1:0]     ld_idx;
  logic [N*DW-1:0]   ld_data;
  logic              res_valid;
  logic              res_ready;
  logic [RW-1:0]     res_data;
  logic [IW-1:0]     res_row;
  logic [IW-1:0]     res_col;
  logic              res_last;

  modport master (
    output ld_valid, ld_sel, ld_idx, ld_data, res_ready,
    input  ld_ready, res_valid, res_data, res_row, res_col, res_last
  );

  modport slave (
    input  ld_valid, ld_sel, ld_idx, ld_data, res_ready,
    output ld_ready, res_valid, res_data, res_row, res_col, res_last
  );

endinterface

// File: rtl/systolic_skew_feeder.sv
// Operand buffers (A by rows, B by columns) and the skewed wavefront muxes
// that present step t to the array's row and column edges.
module systolic_skew_feeder
  import systolic_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_we,
  input  logic            ld_sel,
  input  logic [IW-1:0]   ld_idx,
  input  logic [N*DW-1:0] ld_data,
  input  logic            feed_load,
  input  logic [SW-1:0]   feed_step,
  output logic [N*DW-1:0] arr_data1,
  output logic [N*DW-1:0] arr_data2
);

  logic [N*DW-1:0] buf_a_r [N];
  logic [N*DW-1:0] buf_b_r [N];
  logic [N*DW-1:0] lane_a_s;
  logic [N*DW-1:0] lane_b_s;

  // Operand buffers keep their contents across reset so a run can be repeated
  always_ff @(posedge clk) begin
    if (ld_we) begin
      if (ld_sel == 1'b0) begin
        buf_a_r[ld_idx] <= ld_data;
      end else begin
        buf_b_r[ld_idx] <= ld_data;
      end
    end
  end

  // Lane i carries element t-i of its row/column; negative differences wrap high
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DIFW-1:0] diff_s;
    assign diff_s = {1'b0, feed_step} - DIFW'(i);
    assign lane_a_s[DW*i +: DW] = (diff_s < DIFW'(N)) ? lane_sel(buf_a_r[i], diff_s[IW-1:0]) : {DW{1'b0}};
    assign lane_b_s[DW*i +: DW] = (diff_s < DIFW'(N)) ? lane_sel(buf_b_r[i], diff_s[IW-1:0]) : {DW{1'b0}};
  end

  // Register the wavefront one cycle ahead so it is valid in the FEED cycle of step t
  always_ff @(posedge clk) begin
    if (rst) begin
      arr_data1 <= '0;
      arr_data2 <= '0;
    end else if (feed_load) begin
      arr_data1 <= lane_a_s;
      arr_data2 <= lane_b_s;
    end else begin
      arr_data1 <= '0;
      arr_data2 <= '0;
    end
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for the NxN systolic multiplier: clears the array, feeds skewed
// operands, waits for completion (with timeout) and drains results row-major.
module systolic_seq_ctrl
  import systolic_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  systolic_seq_ctrl_if.slave  bus,
  input  logic                start,
  output logic                busy,
  output logic                err_timeout,
  output logic                arr_rst,
  output logic                arr_ready,
  output logic [N*DW-1:0]     arr_data1,
  output logic [N*DW-1:0]     arr_data2,
  input  logic                arr_all_done,
  output logic [IW-1:0]       arr_addr1,
  output logic [IW-1:0]       arr_addr2,
  input  logic [RW-1:0]       arr_dout
);

  state_t        state_r;
  logic [SW-1:0] step_r;
  logic [TW-1:0] tmo_r;
  logic [IW-1:0] row_r;
  logic [IW-1:0] col_r;
  logic          cap_done_r;
  logic          ld_we_s;
  logic          feed_load_s;
  logic [SW-1:0] feed_step_s;
  logic          cap_s;

  assign ld_we_s   = bus.ld_valid && bus.ld_ready;
  assign arr_addr1 = row_r;
  assign arr_addr2 = col_r;

  systolic_skew_feeder u_feeder (
    .clk       (clk),
    .rst       (rst),
    .ld_we     (ld_we_s),
    .ld_sel    (bus.ld_sel),
    .ld_idx    (bus.ld_idx),
    .ld_data   (bus.ld_data),
    .feed_load (feed_load_s),
    .feed_step (feed_step_s),
    .arr_data1 (arr_data1),
    .arr_data2 (arr_data2)
  );

  // Tell the feeder which step to present next cycle: CLEAR primes t=0, FEED primes t+1
  always_comb begin
    feed_load_s = 1'b0;
    feed_step_s = '0;
    case (state_r)
      CLEAR: begin
        feed_load_s = 1'b1;
        feed_step_s = '0;
      end
      FEED: begin
        if (step_r != SW'(STEPS - 1)) begin
          feed_load_s = 1'b1;
          feed_step_s = step_r + SW'(1);
        end else begin
          feed_load_s = 1'b0;
          feed_step_s = '0;
        end
      end
      default: begin
        feed_load_s = 1'b0;
        feed_step_s = '0;
      end
    endcase
  end

  // Capture the next result when the output register is empty or being emptied
  always_comb begin
    cap_s = 1'b0;
    if ((state_r == DRAIN) && !cap_done_r && (!bus.res_valid || bus.res_ready)) begin
      cap_s = 1'b1;
    end else begin
      cap_s = 1'b0;
    end
  end

  // Main FSM with registered control outputs, timeout counter and drain register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      bus.ld_ready  <= 1'b1;
      busy          <= 1'b0;
      err_timeout   <= 1'b0;
      arr_rst       <= 1'b0;
      arr_ready     <= 1'b0;
      step_r        <= '0;
      tmo_r         <= '0;
      row_r         <= '0;
      col_r         <= '0;
      cap_done_r    <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_row   <= '0;
      bus.res_col   <= '0;
      bus.res_last  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r      <= CLEAR;
            bus.ld_ready <= 1'b0;
            busy         <= 1'b1;
            err_timeout  <= 1'b0;
            arr_rst      <= 1'b1;
          end
        end
        CLEAR: begin
          state_r   <= FEED;
          arr_rst   <= 1'b0;
          arr_ready <= 1'b1;
          step_r    <= '0;
        end
        FEED: begin
          if (step_r == SW'(STEPS - 1)) begin
            state_r <= WAIT;
            tmo_r   <= '0;
          end else begin
            step_r <= step_r + SW'(1);
          end
        end
        WAIT: begin
          if (arr_all_done) begin
            state_r    <= DRAIN;
            arr_ready  <= 1'b0;
            row_r      <= '0;
            col_r      <= '0;
            cap_done_r <= 1'b0;
          end else if (tmo_r == TW'(TIMEOUT - 1)) begin
            state_r      <= IDLE;
            err_timeout  <= 1'b1;
            busy         <= 1'b0;
            bus.ld_ready <= 1'b1;
            arr_ready    <= 1'b0;
          end else begin
            tmo_r <= tmo_r + TW'(1);
          end
        end
        DRAIN: begin
          if (cap_s) begin
            bus.res_valid <= 1'b1;
            bus.res_data  <= arr_dout;
            bus.res_row   <= row_r;
            bus.res_col   <= col_r;
            bus.res_last  <= (row_r == IW'(N - 1)) && (col_r == IW'(N - 1));
            if (col_r == IW'(N - 1)) begin
              if (row_r == IW'(N - 1)) begin
                cap_done_r <= 1'b1;
              end else begin
                col_r <= '0;
                row_r <= row_r + IW'(1);
              end
            end else begin
              col_r <= col_r + IW'(1);
            end
          end else if (bus.res_valid && bus.res_ready) begin
            bus.res_valid <= 1'b0;
            if (bus.res_last) begin
              state_r      <= IDLE;
              busy         <= 1'b0;
              bus.ld_ready <= 1'b1;
              bus.res_last <= 1'b0;
              row_r        <= '0;
              col_r        <= '0;
              cap_done_r   <= 1'b0;
            end
          end
        end
        default: begin
          state_r      <= IDLE;
          busy         <= 1'b0;
          bus.ld_ready <= 1'b1;
          arr_rst      <= 1'b0;
          arr_ready    <= 1'b0;
        end
      endcase
    end
  end

endmodule
